hazard_controller: RTL
======================

// Module: hazard_controller
// PURPOSE
//  Sequences the decode stage: tracks in-flight register writes in EXE/MEM/WB, raises freez to
//  bubble ID on RAW hazards, raises flush on taken branches, and holds the pipe while data memory
//  is busy. Sits beside the decode stage and drives its freez input.
// PARAMETERS
//  REG_ADDR_W   5   register address width
//  PIPE_DEPTH   3   tracked stages after ID (slot0=EXE, slot1=MEM, slot2=WB)
//  STALL_CNT_W  16  width of the saturating stall counter
// PORTS
//  clock        in   1            rising-edge clock
//  reset        in   1            synchronous, active-high
//  id_src1      in   REG_ADDR_W   instruction[25:21] in ID
//  id_src2      in   REG_ADDR_W   instruction[20:16] in ID
//  id_two_regs  in   1            src2 is a real read (decode two_regs)
//  id_wb_en     in   1            unmuxed writeback enable of ID instruction
//  id_mem_read  in   1            unmuxed mem_read of ID instruction (load)
//  id_dest      in   REG_ADDR_W   destination register of ID instruction
//  exe_br_taken in   1            branch resolved taken in EXE this cycle
//  mem_ready    in   1            data memory can complete; 0 = pipe hold
//  freez        out  1            bubble ID, hold PC and IF/ID
//  flush        out  1            squash IF/ID contents
//  pipe_hold    out  1            freeze every stage register (= !mem_ready)
//  stall_count  out  STALL_CNT_W  cycles with freez=1 and pipe_hold=0
// BEHAVIOUR
//  - Slot i = {valid, dest, is_load}. Reset: all slots invalid, stall_count=0; outputs then
//    freez=0, flush=exe_br_taken, pipe_hold=!mem_ready (all combinational).
//  - match(s) = any valid slot with dest==s and dest!=0. Register 0 never causes a hazard.
//  - hazard = match(id_src1) | (id_two_regs & match(id_src2)).
//  - flush = exe_br_taken. freez = hazard & !flush (branch wins; squashed instr never stalls).
//  - pipe_hold=1: slots and stall_count hold; freez/flush still computed from held state.
//  - pipe_hold=0 edge: slot[i]<=slot[i-1]; slot0 <= {id_wb_en & !freez & !flush, id_dest,
//    id_mem_read}; freez or flush inserts an invalid (bubble) slot.
//  - Latency: a write issued at cycle t blocks dependent reads in cycles t+1..t+PIPE_DEPTH;
//    reader leaves ID at t+PIPE_DEPTH+1 (write-then-read in same cycle is not relied on).
//  - id_wb_en=1 with id_dest=0 enters as valid but never matches.
//  - stall_count saturates at all-ones; no wrap.
//  - Reset mid-stall: next cycle all slots invalid, freez=0, count=0.
// CONFIGURATION
//  HAZARD_FORWARDING_EN defined: forwarding unit exists; hazard only when slot0 valid, is_load,
//    dest matches (load-use), 1 bubble max. Undefined: full scoreboard as above.
// STRUCTURE
//  hazard_pkg: slot struct typedef, REG_ZERO constant, default PIPE_DEPTH.
//  Sub-module hazard_slot_pipe: PIPE_DEPTH-deep slot shift register with hold and bubble insert;
//  top does compare, priority and counter.
// TESTING
//  1 ADD r3 issued, next ID reads r3 as src1 -> freez=1 for 3 cycles, stall_count=3, then 0.
//  2 Write r0 then read r0 -> freez never asserts.
//  3 Immediate (id_two_regs=0) with src2 field = pending r5 -> no stall; two_regs=1 -> stall.
//  4 Hazard and exe_br_taken same cycle -> flush=1, freez=0, bubble enters slot0.
//  5 mem_ready=0 for 4 cycles during stall -> pipe_hold=1, slots/stall_count frozen, resume.
//  6 FORWARDING_EN: LW r7 then ADD uses r7 -> 1 freez cycle; ADD->ADD dependency -> 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the decode-stage hazard controller: in-flight write slot and defaults.
// Optional HAZARD_FORWARDING_EN build restricts hazards to load-use on the EXE slot.
package hazard_pkg;

    localparam int SLOT_ADDR_W        = 5;
    localparam int PIPE_DEPTH_DEFAULT = 3;

    localparam logic [SLOT_ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic                   valid;
        logic [SLOT_ADDR_W-1:0] dest;
        logic                   is_load;
    } slot_t;

endpackage

// File: rtl/hazard_slot_pipe.sv
// Shift register of in-flight writes (slot0=EXE); holds on pipe_hold, bubbles clear valid.
// Latency 1 cycle per stage; hold freezes every slot in place.
module hazard_slot_pipe
    import hazard_pkg::*;
#(
    parameter int DEPTH = PIPE_DEPTH_DEFAULT
) (
    input  logic  clock,
    input  logic  reset,
    input  logic  hold,
    input  logic  bubble,
    input  slot_t slot_in,
    output slot_t slots [DEPTH]
);

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                slots[i] <= '0;
            end
        end else if (!hold) begin
            slots[0]       <= slot_in;
            slots[0].valid <= slot_in.valid & ~bubble;
            for (int i = 1; i < DEPTH; i++) begin
                slots[i] <= slots[i-1];
            end
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// Decode-stage hazard control: RAW stall (freez), branch flush, memory hold, stall counter.
// Outputs are combinational from held slot state; HAZARD_FORWARDING_EN selects load-use only.
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W  = SLOT_ADDR_W,
    parameter int PIPE_DEPTH  = PIPE_DEPTH_DEFAULT,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [REG_ADDR_W-1:0]  id_src1,
    input  logic [REG_ADDR_W-1:0]  id_src2,
    input  logic                   id_two_regs,
    input  logic                   id_wb_en,
    input  logic                   id_mem_read,
    input  logic [REG_ADDR_W-1:0]  id_dest,
    input  logic                   exe_br_taken,
    input  logic                   mem_ready,
    output logic                   freez,
    output logic                   flush,
    output logic                   pipe_hold,
    output logic [STALL_CNT_W-1:0] stall_count
);

    localparam logic [STALL_CNT_W-1:0] CNT_MAX = '1;

    slot_t slots [PIPE_DEPTH];
    slot_t slot_in;
    logic  match1;
    logic  match2;
    logic  hazard;

    always_comb begin
        match1 = 1'b0;
        match2 = 1'b0;
`ifdef HAZARD_FORWARDING_EN
        // ALU results are forwarded; only a load still in EXE cannot be bypassed.
        if (slots[0].valid && slots[0].is_load && slots[0].dest != REG_ZERO) begin
            match1 = (slots[0].dest == id_src1);
            match2 = (slots[0].dest == id_src2);
        end
`else
        for (int i = 0; i < PIPE_DEPTH; i++) begin
            if (slots[i].valid && slots[i].dest != REG_ZERO) begin
                if (slots[i].dest == id_src1) match1 = 1'b1;
                if (slots[i].dest == id_src2) match2 = 1'b1;
            end
        end
`endif
    end

    assign hazard    = match1 | (id_two_regs & match2);
    assign flush     = exe_br_taken;
    assign freez     = hazard & ~flush;
    assign pipe_hold = ~mem_ready;

    assign slot_in = '{valid: id_wb_en, dest: id_dest, is_load: id_mem_read};

    hazard_slot_pipe #(
        .DEPTH (PIPE_DEPTH)
    ) u_slot_pipe (
        .clock   (clock),
        .reset   (reset),
        .hold    (pipe_hold),
        .bubble  (freez | flush),
        .slot_in (slot_in),
        .slots   (slots)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_count <= '0;
        end else if (freez && !pipe_hold && stall_count != CNT_MAX) begin
            stall_count <= stall_count + 1'b1;
        end
    end

endmodule
